hwpe_tcdm_rr_arbiter: RTL and testbench
=======================================

# hwpe_tcdm_rr_arbiter

Round-robin arbiter that shares one TCDM master port among NB_IN HWPE streaming ports (operand loads and result stores), so an accelerator top with three internal ports can run on a single cluster interconnect port. It sits between the accelerator's TCDM-side ports and the cluster TCDM port. It tracks outstanding transactions in an in-order tag FIFO and routes each response back to the port that issued it.

## Interface
- NB_IN, 3, number of requester ports (2..8)
- ADDR_WIDTH, 32, TCDM address width
- DATA_WIDTH, 32, TCDM data width (byte enables DATA_WIDTH/8)
- MAX_OUTSTANDING, 4, tag FIFO depth; power of two, ≥1
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_req  in  NB_IN  per-port request
- in_gnt  out  NB_IN  per-port grant
- in_add  in  NB_IN×ADDR_WIDTH  per-port address
- in_wen  in  NB_IN  per-port write-enable (1 = read, 0 = write, TCDM convention)
- in_be  in  NB_IN×DATA_WIDTH/8  per-port byte enables
- in_data  in  NB_IN×DATA_WIDTH  per-port write data
- in_r_data  out  NB_IN×DATA_WIDTH  response data, broadcast to all ports
- in_r_valid  out  NB_IN  per-port response valid
- out_req / out_gnt / out_add / out_wen / out_be / out_data  out/in/out/out/out/out  1/1/ADDR_WIDTH/1/DATA_WIDTH/8/DATA_WIDTH  shared master port
- out_r_data  in  DATA_WIDTH  response data
- out_r_valid  in  1  response valid
- busy  out  1  tag FIFO non-empty
- err  out  1  sticky: out_r_valid received with tag FIFO empty

## Operation
- Handshake: a transaction completes on a cycle with out_req && out_gnt. Every granted transaction, read or write, returns exactly one out_r_valid, in order, at least 1 cycle after the grant.
- Arbitration: the winner is the first asserted in_req scanning from priority pointer ptr upward, modulo NB_IN. out_add/wen/be/data mux the winner's fields. in_gnt[winner] = out_gnt. All other in_gnt are 0.
- Pointer: on a handshake, ptr ← (winner+1) mod NB_IN. Otherwise ptr holds.
- Lock: if out_req && !out_gnt, the winner index is registered and held until its handshake, even if a higher-priority port raises in_req. A locked port drops in_req only after its grant (TCDM rule). If it deasserts anyway, the lock is released and arbitration resumes next cycle.
- Tag FIFO: on a handshake, push the winner index. On out_r_valid, pop. in_r_valid[head] = out_r_valid. in_r_data[all] = out_r_data.
- Full: while count == MAX_OUTSTANDING, out_req = 0 and all in_gnt = 0. A pop in the same cycle does not lift the block; the pop takes effect next cycle.
- Simultaneous push and pop with count < MAX_OUTSTANDING leaves count unchanged. Count width is clog2(MAX_OUTSTANDING)+1.
- Spurious response (out_r_valid with FIFO empty): all in_r_valid = 0, err ← 1 until reset.

## Timing
- Request path: zero latency. in_req→out_req and out_gnt→in_gnt are combinational, gated by the registered full flag and lock.
- Response path: zero latency. out_r_valid→in_r_valid is combinational from the registered FIFO head.
- Throughput: one grant per cycle while not full. With 1-cycle memory response, MAX_OUTSTANDING ≥ 2 sustains 100 %.
- Reset (asynchronous, rst_n = 0): ptr = 0, lock cleared, FIFO empty (count 0), err = 0, busy = 0, in_r_valid = 0, in_gnt = 0, out_req = 0.
- Reset mid-transfer: outstanding tags are discarded. Responses arriving after reset set err.

## Configuration
- HWPE_TCDM_ARB_PERF_EN defined: adds ports clear (in, 1) and perf_conflicts (out, 32).
  - perf_conflicts counts cycles where ≥2 in_req are asserted and not blocked by full.
  - The counter saturates at 2^32−1 and is synchronously zeroed by clear.
  - It resets to 0 on rst_n.
- Undefined: neither port nor counter exists. Behaviour is otherwise identical.

## Test plan
- Fairness: NB_IN = 3, all in_req held high, out_gnt = 1, 1-cycle responses → grants ordered 0,1,2,0,1,2… with no bubbles. Each in_r_valid arrives one cycle after its port's grant.
- Lock: port 1 requests with out_gnt = 0 for 3 cycles; port 0 raises in_req in cycle 2 → out_add stays port 1's address until port 1's grant. Port 0 is granted next.
- Full: MAX_OUTSTANDING = 4, responses withheld, continuous requests → exactly 4 grants, then out_req = 0 and busy = 1. One out_r_valid → a grant resumes the following cycle.
- Routing: grants to ports 2,0,2 with responses 0xA, 0xB, 0xC delayed 5 cycles → in_r_valid[2], [0], [2] in order with the matching data.
- Errors/reset: out_r_valid with an empty FIFO → err = 1 and no in_r_valid. Asserting rst_n low with 2 tags outstanding → count = 0, ptr = 0, err = 0.
- Perf (macro defined): ports 0 and 1 request together for 10 cycles → perf_conflicts = 10. clear → 0.

Source files
------------

// File: rtl/hwpe_tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM master port among NB_IN HWPE ports, with an in-order tag FIFO for response routing.
// Optional conflict counter (ports clear, perf_conflicts) enabled by defining HWPE_TCDM_ARB_PERF_EN.
module hwpe_tcdm_rr_arbiter #(
   parameter int unsigned NB_IN           = 3,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
`ifdef HWPE_TCDM_ARB_PERF_EN
   input  logic                                  clear,
   output logic [31:0]                           perf_conflicts,
`endif
   input  logic [NB_IN-1:0]                      in_req,
   output logic [NB_IN-1:0]                      in_gnt,
   input  logic [NB_IN-1:0][ADDR_WIDTH-1:0]      in_add,
   input  logic [NB_IN-1:0]                      in_wen,
   input  logic [NB_IN-1:0][DATA_WIDTH/8-1:0]    in_be,
   input  logic [NB_IN-1:0][DATA_WIDTH-1:0]      in_data,
   output logic [NB_IN-1:0][DATA_WIDTH-1:0]      in_r_data,
   output logic [NB_IN-1:0]                      in_r_valid,
   output logic                                  out_req,
   input  logic                                  out_gnt,
   output logic [ADDR_WIDTH-1:0]                 out_add,
   output logic                                  out_wen,
   output logic [DATA_WIDTH/8-1:0]               out_be,
   output logic [DATA_WIDTH-1:0]                 out_data,
   input  logic [DATA_WIDTH-1:0]                 out_r_data,
   input  logic                                  out_r_valid,
   output logic                                  busy,
   output logic                                  err
);

   localparam int unsigned IDX_W = (NB_IN > 1) ? $clog2(NB_IN) : 1;
   localparam int unsigned AW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   logic [IDX_W-1:0] ptr_q, lock_idx_q, winner;
   logic             lock_q, any_req, handshake, full, empty, pop;
   logic [IDX_W-1:0] tag_q [MAX_OUTSTANDING];
   logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             err_q;
   logic [IDX_W-1:0] head;

   function automatic logic [AW-1:0] fifo_next(input logic [AW-1:0] p);
      if (int'(p) == MAX_OUTSTANDING - 1) return '0;
      return p + AW'(1);
   endfunction

   assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));
   assign empty = (count_q == '0);
   assign busy  = !empty;
   assign err   = err_q;

   // Winner selection: a locked port keeps the bus; otherwise first requester from ptr upward
   always_comb begin
      any_req = 1'b0;
      winner  = '0;
      if (lock_q) begin
         any_req = in_req[lock_idx_q];
         winner  = lock_idx_q;
      end else begin
         for (int i = NB_IN - 1; i >= 0; i--) begin
            if (in_req[(int'(ptr_q) + i) % NB_IN]) begin
               any_req = 1'b1;
               winner  = IDX_W'((int'(ptr_q) + i) % NB_IN);
            end
         end
      end
   end

   assign out_req   = any_req && !full;
   assign handshake = out_req && out_gnt;
   assign out_add   = in_add[winner];
   assign out_wen   = in_wen[winner];
   assign out_be    = in_be[winner];
   assign out_data  = in_data[winner];

   assign head = tag_q[rd_ptr_q];
   assign pop  = out_r_valid && !empty;

   always_comb begin
      in_gnt     = '0;
      in_r_valid = '0;
      for (int i = 0; i < NB_IN; i++) begin
         in_gnt[i]     = handshake && (winner == IDX_W'(i));
         in_r_valid[i] = pop && (head == IDX_W'(i));
         in_r_data[i]  = out_r_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         lock_q     <= out_req && !out_gnt;
         lock_idx_q <= winner;
         if (handshake) begin
            ptr_q    <= (int'(winner) == NB_IN - 1) ? '0 : winner + IDX_W'(1);
            wr_ptr_q <= fifo_next(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= fifo_next(rd_ptr_q);
         if (handshake && !pop)      count_q <= count_q + CNT_W'(1);
         else if (pop && !handshake) count_q <= count_q - CNT_W'(1);
         if (out_r_valid && empty) err_q <= 1'b1;
      end
   end

   // Tag storage holds data only; validity is tracked by the pointers and count
   always_ff @(posedge clk) begin
      if (handshake) tag_q[wr_ptr_q] <= winner;
   end

`ifdef HWPE_TCDM_ARB_PERF_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   function automatic logic multi_req(input logic [NB_IN-1:0] v);
      return |(v & (v - NB_IN'(1)));
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             perf_conflicts <= '0;
      else if (clear)                         perf_conflicts <= '0;
      else if (multi_req(in_req) && !full)    perf_conflicts <= sat_inc(perf_conflicts);
   end
`endif

endmodule

// File: tb/tb_hwpe_tcdm_rr_arbiter.sv
// Directed bench for hwpe_tcdm_rr_arbiter (NB_IN=3, MAX_OUTSTANDING=4): vector table plus corner-case sequences.
module tb_hwpe_tcdm_rr_arbiter;

   localparam int NB = 3;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NB-1:0]            in_req = '0;
   logic [NB-1:0]            in_gnt;
   logic [NB-1:0][AW-1:0]    in_add;
   logic [NB-1:0]            in_wen;
   logic [NB-1:0][DW/8-1:0]  in_be;
   logic [NB-1:0][DW-1:0]    in_data;
   logic [NB-1:0][DW-1:0]    in_r_data;
   logic [NB-1:0]            in_r_valid;
   logic                     out_req, out_gnt = 1'b0, out_wen, out_r_valid = 1'b0;
   logic [AW-1:0]            out_add;
   logic [DW/8-1:0]          out_be;
   logic [DW-1:0]            out_data, out_r_data = '0;
   logic                     busy, err;
`ifdef HWPE_TCDM_ARB_PERF_EN
   logic                     clear = 1'b0;
   logic [31:0]              perf_conflicts;
`endif

   int pass_cnt = 0;
   int tot_cnt  = 0;

   always #5 clk = ~clk;

   hwpe_tcdm_rr_arbiter #(.NB_IN(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4)) dut (
      .clk(clk), .rst_n(rst_n),
`ifdef HWPE_TCDM_ARB_PERF_EN
      .clear(clear), .perf_conflicts(perf_conflicts),
`endif
      .in_req(in_req), .in_gnt(in_gnt), .in_add(in_add), .in_wen(in_wen), .in_be(in_be),
      .in_data(in_data), .in_r_data(in_r_data), .in_r_valid(in_r_valid),
      .out_req(out_req), .out_gnt(out_gnt), .out_add(out_add), .out_wen(out_wen),
      .out_be(out_be), .out_data(out_data), .out_r_data(out_r_data), .out_r_valid(out_r_valid),
      .busy(busy), .err(err)
   );

   typedef struct {
      logic [NB-1:0] req;
      logic          gnt;
      logic          rv;
      logic [DW-1:0] rdata;
      logic [NB-1:0] e_gnt;
      logic          e_req;
      int            e_win;
      logic [NB-1:0] e_rv;
      logic          e_busy;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // inputs change 1 time unit after the rising edge; outputs are checked mid-cycle
   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [NB-1:0] req, input logic gnt, input logic rv, input logic [DW-1:0] rd);
      in_req = req; out_gnt = gnt; out_r_valid = rv; out_r_data = rd;
      #4;
   endtask

   task automatic do_reset();
      in_req = '0; out_gnt = 1'b0; out_r_valid = 1'b0;
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      adv();
   endtask

   initial begin
      for (int i = 0; i < NB; i++) begin
         in_add[i]  = 32'h1000 + 32'(i) * 32'h100;
         in_wen[i]  = i[0];
         in_be[i]   = 4'(i + 1);
         in_data[i] = 32'hD000 + 32'(i);
      end

      // fairness: all ports requesting, 1-cycle responses
      tbl[0] = '{3'b111, 1'b1, 1'b0, 32'h0,  3'b001, 1'b1, 0, 3'b000, 1'b0};
      tbl[1] = '{3'b111, 1'b1, 1'b1, 32'h11, 3'b010, 1'b1, 1, 3'b001, 1'b1};
      tbl[2] = '{3'b111, 1'b1, 1'b1, 32'h22, 3'b100, 1'b1, 2, 3'b010, 1'b1};
      tbl[3] = '{3'b111, 1'b1, 1'b1, 32'h33, 3'b001, 1'b1, 0, 3'b100, 1'b1};
      tbl[4] = '{3'b111, 1'b1, 1'b1, 32'h44, 3'b010, 1'b1, 1, 3'b001, 1'b1};
      tbl[5] = '{3'b000, 1'b1, 1'b1, 32'h55, 3'b000, 1'b0, 0, 3'b010, 1'b1};
      tbl[6] = '{3'b000, 1'b0, 1'b0, 32'h0,  3'b000, 1'b0, 0, 3'b000, 1'b0};

      // reset state
      rst_n = 1'b0;
      #2;
      chk("rst_out_req", out_req, 0);
      chk("rst_in_gnt", in_gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_in_r_valid", in_r_valid, 0);
      #1;
      rst_n = 1'b1;
      adv();

      for (int k = 0; k < 7; k++) begin
         drive(tbl[k].req, tbl[k].gnt, tbl[k].rv, tbl[k].rdata);
         chk($sformatf("fair%0d_gnt", k), in_gnt, tbl[k].e_gnt);
         chk($sformatf("fair%0d_req", k), out_req, tbl[k].e_req);
         chk($sformatf("fair%0d_rv", k), in_r_valid, tbl[k].e_rv);
         chk($sformatf("fair%0d_busy", k), busy, tbl[k].e_busy);
         if (tbl[k].e_req) begin
            chk($sformatf("fair%0d_add", k), out_add, 32'h1000 + 32'(tbl[k].e_win) * 32'h100);
            chk($sformatf("fair%0d_data", k), out_data, 32'hD000 + 32'(tbl[k].e_win));
            chk($sformatf("fair%0d_be", k), out_be, 4'(tbl[k].e_win + 1));
         end
         if (tbl[k].rv) chk($sformatf("fair%0d_rdata", k), in_r_data[2], tbl[k].rdata);
         adv();
      end

      // lock: port 1 stalls, port 0 joins, port 1 keeps the bus until granted
      do_reset();
      drive(3'b010, 1'b0, 1'b0, 0);
      chk("lock_c1_add", out_add, 32'h1100);
      chk("lock_c1_gnt", in_gnt, 3'b000);
      adv();
      drive(3'b011, 1'b0, 1'b0, 0);
      chk("lock_c2_add", out_add, 32'h1100);
      adv();
      drive(3'b011, 1'b0, 1'b0, 0);
      chk("lock_c3_add", out_add, 32'h1100);
      adv();
      drive(3'b011, 1'b1, 1'b0, 0);
      chk("lock_grant1", in_gnt, 3'b010);
      chk("lock_grant1_add", out_add, 32'h1100);
      adv();
      drive(3'b001, 1'b1, 1'b0, 0);
      chk("lock_grant0", in_gnt, 3'b001);
      adv();
      drive(3'b000, 1'b0, 1'b1, 32'h77);
      chk("lock_resp1", in_r_valid, 3'b010);
      adv();
      drive(3'b000, 1'b0, 1'b1, 32'h78);
      chk("lock_resp0", in_r_valid, 3'b001);
      adv();

      // full: four grants without responses, then the block, then one pop
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drive(3'b111, 1'b1, 1'b0, 0);
         chk($sformatf("full_g%0d", k), in_gnt, 3'b001 << (k % 3));
         adv();
      end
      drive(3'b111, 1'b1, 1'b0, 0);
      chk("full_req", out_req, 0);
      chk("full_gnt", in_gnt, 0);
      chk("full_busy", busy, 1);
      adv();
      drive(3'b111, 1'b1, 1'b1, 32'h9);
      chk("full_pop_req", out_req, 0);
      chk("full_pop_rv", in_r_valid, 3'b001);
      adv();
      drive(3'b111, 1'b1, 1'b0, 0);
      chk("full_resume", in_gnt, 3'b010);
      adv();
      begin
         logic [NB-1:0] order [4];
         order[0] = 3'b010; order[1] = 3'b100; order[2] = 3'b001; order[3] = 3'b010;
         for (int k = 0; k < 4; k++) begin
            drive(3'b000, 1'b0, 1'b1, 32'(k));
            chk($sformatf("full_drain%0d", k), in_r_valid, order[k]);
            adv();
         end
      end
      drive(3'b000, 1'b0, 1'b0, 0);
      chk("full_idle_busy", busy, 0);
      adv();

      // routing: grants 2,0,2 answered late
      do_reset();
      drive(3'b100, 1'b1, 1'b0, 0);
      chk("route_g2a", in_gnt, 3'b100);
      adv();
      drive(3'b001, 1'b1, 1'b0, 0);
      chk("route_g0", in_gnt, 3'b001);
      adv();
      drive(3'b100, 1'b1, 1'b0, 0);
      chk("route_g2b", in_gnt, 3'b100);
      adv();
      for (int k = 0; k < 5; k++) begin
         drive(3'b000, 1'b0, 1'b0, 0);
         adv();
      end
      chk("route_wait_busy", busy, 1);
      drive(3'b000, 1'b0, 1'b1, 32'hA);
      chk("route_rA", in_r_valid, 3'b100);
      chk("route_dA", in_r_data[2], 32'hA);
      adv();
      drive(3'b000, 1'b0, 1'b1, 32'hB);
      chk("route_rB", in_r_valid, 3'b001);
      chk("route_dB", in_r_data[0], 32'hB);
      adv();
      drive(3'b000, 1'b0, 1'b1, 32'hC);
      chk("route_rC", in_r_valid, 3'b100);
      chk("route_dC", in_r_data[2], 32'hC);
      adv();
      drive(3'b000, 1'b0, 1'b0, 0);
      chk("route_err", err, 0);
      adv();

      // spurious response, then reset with two tags outstanding
      do_reset();
      drive(3'b000, 1'b0, 1'b1, 32'h5);
      chk("spur_rv", in_r_valid, 3'b000);
      adv();
      drive(3'b000, 1'b0, 1'b0, 0);
      chk("spur_err", err, 1);
      adv();
      drive(3'b011, 1'b1, 1'b0, 0);
      adv();
      drive(3'b011, 1'b1, 1'b0, 0);
      adv();
      drive(3'b000, 1'b0, 1'b0, 0);
      chk("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_err", err, 0);
      chk("mid_rst_req", out_req, 0);
      rst_n = 1'b1;
      adv();
      drive(3'b111, 1'b0, 1'b0, 0);
      chk("post_rst_ptr", out_add, 32'h1000);
      adv();
      drive(3'b000, 1'b0, 1'b1, 32'h6);
      chk("post_rst_rv", in_r_valid, 3'b000);
      adv();
      drive(3'b000, 1'b0, 1'b0, 0);
      chk("post_rst_err", err, 1);
      adv();

`ifdef HWPE_TCDM_ARB_PERF_EN
      do_reset();
      for (int k = 0; k < 10; k++) begin
         drive(3'b011, 1'b0, 1'b0, 0);
         adv();
      end
      drive(3'b000, 1'b0, 1'b0, 0);
      chk("perf_count", perf_conflicts, 10);
      clear = 1'b1;
      adv();
      clear = 1'b0;
      #4;
      chk("perf_clear", perf_conflicts, 0);
      adv();
`endif

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
